// File: rtl/stv_arb_pkg.sv
// Shared arbiter helpers: lock-state encoding, one-hot to binary conversion and
// thermometer masks. Functions operate on MaxInputs-wide vectors; callers zero-extend.
package stv_arb_pkg;

  localparam int unsigned MaxInputs = 64;

  typedef enum logic [0:0] {
    StIdle,
    StXfer
  } lock_state_e;

  function automatic int unsigned onehot2bin(input logic [MaxInputs-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxInputs; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

  // Bits 0..idx set: everything at or below idx becomes lowest priority.
  function automatic logic [MaxInputs-1:0] thermo(input int unsigned idx);
    logic [MaxInputs-1:0] t;
    for (int unsigned i = 0; i < MaxInputs; i++) begin
      t[i] = (i <= idx);
    end
    return t;
  endfunction

endpackage

// File: rtl/stv_rr_picker.sv
// Combinational round-robin pick: lowest set bit of req & ~mask, falling back to
// unmasked req when nothing survives the mask. Also returns the thermometer of the pick.
module stv_rr_picker #(
  parameter int unsigned Inputs = 8
) (
  input  logic [Inputs-1:0] req_i,
  input  logic [Inputs-1:0] mask_i,
  output logic [Inputs-1:0] gnt_o,
  output logic [Inputs-1:0] thermo_o
);

  logic [Inputs-1:0] masked;
  logic [Inputs-1:0] cand;
  logic              found;

  always_comb begin
    masked   = req_i & ~mask_i;
    cand     = (|masked) ? masked : req_i;
    gnt_o    = '0;
    thermo_o = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < Inputs; i++) begin
      if (!found) thermo_o[i] = 1'b1;
      if (cand[i] && !found) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stv_wrr_arbiter.sv
// Weighted round-robin arbiter: each owner keeps the grant for up to weight transfers,
// and a multi-beat transfer locks the grant until its last beat is accepted.
module stv_wrr_arbiter
  import stv_arb_pkg::*;
#(
  parameter int unsigned INPUTS   = 8,
  parameter int unsigned WEIGHT_W = 4,
  localparam int unsigned IdxW    = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic [INPUTS-1:0]            req,
  input  logic [INPUTS*WEIGHT_W-1:0]   weight,
  input  logic                         ready,
  input  logic                         last,
  output logic [INPUTS-1:0]            gnt,
  output logic [IdxW-1:0]              gnt_idx,
  output logic                         busy
);

  lock_state_e         state_q, state_d;
  logic [INPUTS-1:0]   owner_q, owner_d;
  logic [INPUTS-1:0]   mask_q, mask_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;

  logic [INPUTS-1:0]    pick_gnt, pick_thermo;
  logic [MaxInputs-1:0] owner_thermo_full;
  logic [INPUTS-1:0]    gnt_thermo;
  logic                 locked, cont, accept, new_owner;
  int unsigned          idx;
  logic [WEIGHT_W-1:0]  wsel, cnt_upd;

  stv_rr_picker #(
    .Inputs (INPUTS)
  ) u_picker (
    .req_i    (req),
    .mask_i   (mask_q),
    .gnt_o    (pick_gnt),
    .thermo_o (pick_thermo)
  );

  assign locked = (state_q == StXfer);
  assign cont   = (|(owner_q & req)) && (cnt_q != '0);
  assign busy   = locked;

  always_comb begin
    gnt               = (locked || cont) ? owner_q : pick_gnt;
    idx               = onehot2bin(MaxInputs'(gnt));
    gnt_idx           = IdxW'(idx);
    owner_thermo_full = thermo(onehot2bin(MaxInputs'(owner_q)));
    // Reuse the picker's thermometer unless the grant came from the held owner.
    gnt_thermo        = (locked || cont) ? owner_thermo_full[INPUTS-1:0] : pick_thermo;
    accept            = (|gnt) && ready;
    wsel              = weight[idx*WEIGHT_W +: WEIGHT_W];
    new_owner         = (gnt != owner_q) || (cnt_q == '0);
    if (new_owner) begin
      cnt_upd = (wsel == '0) ? '0 : wsel - WEIGHT_W'(1);
    end else begin
      cnt_upd = cnt_q - WEIGHT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (accept && !last) state_d = StXfer;
      StXfer: if (accept && last)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (accept) begin
      owner_d = gnt;
      if (last) begin
        cnt_d = cnt_upd;
        if (cnt_upd == '0) mask_d = gnt_thermo;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STV_ASSERT_ON
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!arst_n) $onehot0(gnt));
  a_gnt_req     : assert property (@(posedge clk) disable iff (!arst_n)
                                   !locked |-> ((gnt & ~req) == '0));
  a_busy_stable : assert property (@(posedge clk) disable iff (!arst_n) busy |-> $stable(gnt));
`endif

endmodule
